// File: rtl/ysyx_23060208_ifu_prefetch_pkg.sv
// ysyx_23060208_ifu_prefetch_pkg: IFU fetch FSM encodings, AXI response codes and IFU->IDU bus width.
package ysyx_23060208_ifu_prefetch_pkg;

    typedef enum logic [1:0] {
        IFU_S_IDLE = 2'd0,
        IFU_S_AR   = 2'd1,
        IFU_S_R    = 2'd2
    } ifu_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // {pc, inst, fault}
    function automatic int ifu_to_idu_bus_w(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

endpackage

// File: rtl/ysyx_23060208_ifu_prefetch_if.sv
// ysyx_23060208_ifu_prefetch_if: instruction SRAM read channel plus IFU->IDU valid/ready bus.
interface ysyx_23060208_ifu_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic [1:0]            rresp;
    logic                  rready;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_inst;
    logic                  out_fault;

    modport master (
        output araddr, arvalid, rready, out_valid, out_pc, out_inst, out_fault,
        input  arready, rdata, rvalid, rresp, out_ready
    );

    modport slave (
        input  araddr, arvalid, rready, out_valid, out_pc, out_inst, out_fault,
        output arready, rdata, rvalid, rresp, out_ready
    );

endinterface

// File: rtl/ysyx_23060208_ifu_fifo.sv
// ysyx_23060208_ifu_fifo: DEPTH x WIDTH synchronous FIFO with flush and occupancy count (DEPTH power of two).
module ysyx_23060208_ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_count;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push && !i_flush) r_mem[r_wr] <= i_data;
            if (i_flush) begin
                r_rd    <= '0;
                r_wr    <= '0;
                r_count <= '0;
            end else begin
                r_wr    <= r_wr + AW'(w_push);
                r_rd    <= r_rd + AW'(w_pop);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

endmodule

// File: rtl/ysyx_23060208_ifu_prefetch.sv
// ysyx_23060208_ifu_prefetch: run-ahead sequential IFU with prefetch FIFO and redirect flush/squash.
// Define IFU_PERF_CNT_EN to add fetch/stall/flush performance counter ports.
module ysyx_23060208_ifu_prefetch
    import ysyx_23060208_ifu_prefetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    ysyx_23060208_ifu_prefetch_if.master bus
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]           o_perf_fetch_cnt,
    output logic [31:0]           o_perf_stall_cnt,
    output logic [31:0]           o_perf_flush_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = ifu_to_idu_bus_w(ADDR_WIDTH, DATA_WIDTH);

    ifu_state_e            r_state;
    ifu_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [ADDR_WIDTH-1:0] w_araddr_nxt;
    logic                  r_stale;
    logic                  w_stale_nxt;
    logic                  r_halted;
    logic                  w_halt_nxt;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_fault;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_nxt;
    logic [BW-1:0]         w_head;

    assign w_ar_hs = r_state == IFU_S_AR && bus.arready;
    assign w_r_hs  = r_state == IFU_S_R && bus.rvalid;
    assign w_fault = bus.rresp != RESP_OKAY;
    assign w_push  = w_r_hs && !r_stale && !i_redirect_valid && !w_full;
    assign w_pop   = !w_empty && bus.out_ready;

    // Credit is judged on the occupancy after this cycle's push/pop so a
    // full FIFO never has a request outstanding whose data it cannot hold.
    assign w_count_nxt = i_redirect_valid ? '0 : w_count + CW'(w_push) - CW'(w_pop);
    assign w_halt_nxt  = i_redirect_valid ? 1'b0 : r_halted || (w_push && w_fault);
    assign w_issue     = w_count_nxt < CW'(DEPTH) && !w_halt_nxt;

    assign w_fetch_pc_nxt = i_redirect_valid ? i_redirect_pc :
                            (w_ar_hs && !r_stale) ? r_fetch_pc + ADDR_WIDTH'(PC_STEP) : r_fetch_pc;

    // Only the request already on the bus (AR, or R still waiting) turns stale;
    // a response completing this cycle leaves nothing in flight.
    assign w_stale_nxt = i_redirect_valid ? (r_state == IFU_S_AR || (r_state == IFU_S_R && !bus.rvalid)) :
                         w_r_hs ? 1'b0 : r_stale;

    always_comb begin
        w_state_nxt  = r_state;
        w_araddr_nxt = r_araddr;
        case (r_state)
            IFU_S_IDLE: w_state_nxt = w_issue ? IFU_S_AR : IFU_S_IDLE;
            IFU_S_AR:   w_state_nxt = bus.arready ? IFU_S_R : IFU_S_AR;
            IFU_S_R:    w_state_nxt = !bus.rvalid ? IFU_S_R : w_issue ? IFU_S_AR : IFU_S_IDLE;
            default:    w_state_nxt = IFU_S_IDLE;
        endcase
        if (w_state_nxt == IFU_S_AR && r_state != IFU_S_AR)
            w_araddr_nxt = i_redirect_valid ? i_redirect_pc : r_fetch_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IFU_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_araddr   <= '0;
            r_stale    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_araddr   <= w_araddr_nxt;
            r_stale    <= w_stale_nxt;
            r_halted   <= w_halt_nxt;
        end
    end

    assign bus.arvalid = r_state == IFU_S_AR;
    assign bus.araddr  = r_araddr;
    assign bus.rready  = r_state == IFU_S_R;

    ysyx_23060208_ifu_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_redirect_valid),
        .i_push  (w_push),
        .i_data  ({r_araddr, bus.rdata, w_fault}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_pc    = w_head[BW-1 -: ADDR_WIDTH];
    assign bus.out_inst  = w_head[DATA_WIDTH:1];
    assign bus.out_fault = w_head[0];

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_perf_fetch_cnt <= '0;
            o_perf_stall_cnt <= '0;
            o_perf_flush_cnt <= '0;
        end else begin
            o_perf_fetch_cnt <= o_perf_fetch_cnt + 32'(w_push);
            o_perf_stall_cnt <= o_perf_stall_cnt + 32'(bus.out_ready && w_empty);
            o_perf_flush_cnt <= o_perf_flush_cnt + 32'(i_redirect_valid);
        end
    end
`endif

endmodule
